sram_bitstream_reader: RTL
==========================

Name: sram_bitstream_reader

Overview:
- Downstream consumer of the UART-to-SRAM loader. After the host stream lands in SRAM from word address 76800 upward, this block reads the compressed bitstream back as 16-bit words.
- It buffers the words into an MSB-first bit window and hands variable-length bit fields (1..16 bits per cycle) to the decoder stage.
- It owns the SRAM address and write enable only while its owner grants it the SRAM; the loader and this block never drive the SRAM concurrently.

Parameters:
- READ_LATENCY, 2, cycles from SRAM_address presented to SRAM_read_data valid.
- BUF_W, 64, bit-buffer width; must be at least 16*(READ_LATENCY+1)+16.
- END_ADDRESS, 18'h3FFFF, last word address fetched.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  one-cycle pulse; flush and begin fetching at Base_address.
- Base_address  in  18  first word address, sampled on Start.
- SRAM_address  out  18  read address.
- SRAM_we_n  out  1  held 1 (read-only block).
- SRAM_read_data  in  16  read data, valid READ_LATENCY cycles after address.
- Bits_out  out  16  top 16 buffer bits; Bits_out[15] is the oldest bit.
- Bits_valid  out  1  buffer holds at least 16 bits.
- Consume_en  in  1  decoder consumes Consume_count bits this cycle.
- Consume_count  in  5  1..16; 0 or more than 16 is treated as a no-op.
- Busy  out  1  state is not S_BR_IDLE.
- Exhausted  out  1  END_ADDRESS has been issued; no further fetches.
- Underflow  out  1  sticky: a consume was attempted with too few bits.

Behaviour:
- Reset (sync, Clock edge with Reset=1):
  - state=S_BR_IDLE; buffer=0, bit_count=0; inflight pipeline cleared.
  - SRAM_address=0, SRAM_we_n=1, Bits_valid=0, Busy=0, Exhausted=0, Underflow=0.
  - Reset has priority over Start and over every other input.
- States:
  - S_BR_IDLE -> (Start) S_BR_RUN.
  - S_BR_RUN -> (END_ADDRESS issued) S_BR_DRAIN.
  - S_BR_DRAIN -> (inflight empty and bit_count<16) S_BR_IDLE. Leftover bits (bit_count<16) are discarded and Exhausted stays 1.
- Start in any state:
  - Flushes the buffer, bit_count=0, clears the inflight valid pipeline so returning stale data is dropped.
  - Clears Underflow and Exhausted, loads SRAM_address=Base_address, enters S_BR_RUN.
  - Start takes priority over a same-cycle Consume_en, which is ignored.
- Fetch issue, in S_BR_RUN only:
  - A read issues in cycle t when bit_count + 16*inflight + 16 <= BUF_W, using registered values. This is conservative, so consume in the same cycle is not credited.
  - The first issue is in the cycle after the Start edge, at Base_address.
  - SRAM_address increments by 1 on the edge ending each issue cycle.
  - Issuing END_ADDRESS sets Exhausted and enters S_BR_DRAIN; the address holds at END_ADDRESS and never wraps.
- Return:
  - Data issued in cycle t is captured at the end of cycle t+READ_LATENCY.
  - After any same-cycle consume, its bits land directly below the remaining valid bits: buffer_next = (buffer << k) | (word << (BUF_W-16-(bit_count-k))), and bit_count_next = bit_count - k + 16.
- Consume:
  - Legal when Consume_en=1, 1<=k<=16, and k<=bit_count (registered).
  - Legal consume: buffer shifts left by k, bit_count decreases by k.
  - Illegal consume (k>bit_count): no state change; Underflow<=1.
  - k=0 or k>16: ignored.
- Outputs:
  - Bits_out = buffer[BUF_W-1:BUF_W-16], registered.
  - Bits_valid = (bit_count>=16), registered.
  - Bits_out bits beyond bit_count are 0.
- Latency:
  - Start sampled at edge E0; address issued in cycle 1; data captured at edge E3.
  - Bits_valid=1 and Bits_out = word[Base] in the cycle after E3, i.e. after 4 edges.
- Throughput: with BUF_W=64 and READ_LATENCY=2, a steady 16 bits/cycle is sustained after fill.
- Widths:
  - bit_count is 7 bits and never exceeds BUF_W; assertion bit_count<=64.
  - inflight is a READ_LATENCY-bit valid shift register; popcount gives the inflight term.

Test Plan:
- Reset=1 mid-stream with Start=1 same cycle -> next cycle Busy=0, Bits_valid=0, SRAM_address=0, Underflow=0, no fetch issued.
- SRAM preloaded 76800:16'hA5C3, 76801:16'h0FF0, Start with Base=76800 -> Bits_out=16'hA5C3 with Bits_valid exactly 4 edges after Start. Then Consume 4 -> Bits_out=16'h5C30; Consume 12 -> Bits_out=16'h0FF0.
- Continuous Consume 16 every cycle over 1000 words of pseudo-random data -> Bits_out matches the SRAM word sequence in order, no bubbles after the initial fill, and bit_count never exceeds 64.
- Odd-length consumes (3,7,1,16,5 repeated) checked against a bit-serial reference model -> exact bit match, no Underflow.
- Base=18'h3FFFE -> exactly 2 reads issued, Exhausted=1 after 3FFFF issued, SRAM_address stays 3FFFF. After 32 bits consumed -> Busy=0; a further Consume 1 -> Underflow=1.
- Start pulsed while 2 reads are inflight, Base=100 -> the stale returns are dropped and the first Bits_out equals word[100], 4 edges after the new Start.

Source files
------------

// File: rtl/sram_bitstream_reader_if.sv
// SRAM read port plus the bit-window hand-off to the decoder, grouped as one bundle.
// master = the bitstream reader, slave = SRAM model + decoder side.
interface sram_bitstream_reader_if;
    logic [17:0] SRAM_address;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data;
    logic [15:0] Bits_out;
    logic        Bits_valid;
    logic        Consume_en;
    logic [4:0]  Consume_count;

    modport master (
        output SRAM_address, SRAM_we_n, Bits_out, Bits_valid,
        input  SRAM_read_data, Consume_en, Consume_count
    );

    modport slave (
        input  SRAM_address, SRAM_we_n, Bits_out, Bits_valid,
        output SRAM_read_data, Consume_en, Consume_count
    );
endinterface

// File: rtl/sram_bitstream_reader.sv
// Streams 16-bit SRAM words into an MSB-first bit window and lets the decoder
// pull 1..16 bits per cycle; fetches are throttled so returning data always fits.
module sram_bitstream_reader #(
    parameter int          READ_LATENCY = 2,
    parameter int          BUF_W        = 64,
    parameter logic [17:0] END_ADDRESS  = 18'h3FFFF
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Start,
    input  logic [17:0]               Base_address,
    sram_bitstream_reader_if.master   bus,
    output logic                      Busy,
    output logic                      Exhausted,
    output logic                      Underflow
);
    localparam int CNT_W  = $clog2(BUF_W + 1);
    localparam int FILL_W = CNT_W + 5;

    typedef enum logic [1:0] {S_BR_IDLE, S_BR_RUN, S_BR_DRAIN} br_state_t;

    br_state_t               state, state_next;
    logic [BUF_W-1:0]        buffer, buffer_next;
    logic [CNT_W-1:0]        bit_count, bit_count_next;
    logic [READ_LATENCY-1:0] inflight, inflight_next;
    logic [17:0]             address, address_next;
    logic                    exhausted_next, underflow_next;

    logic                    issue, ret, consume_req, take;
    logic [CNT_W-1:0]        k, k_eff, remain, shamt;
    logic [FILL_W-1:0]       inflight_cnt, fill_level;

    always_comb begin
        state_next     = state;
        buffer_next    = buffer;
        bit_count_next = bit_count;
        inflight_next  = inflight;
        address_next   = address;
        exhausted_next = Exhausted;
        underflow_next = Underflow;
        k_eff          = '0;
        remain         = bit_count;
        shamt          = '0;

        inflight_cnt = '0;
        for (int i = 0; i < READ_LATENCY; i++)
            inflight_cnt = inflight_cnt + FILL_W'(inflight[i]);

        // Worst case: every inflight word lands with no consume credited.
        fill_level = FILL_W'(bit_count) + (inflight_cnt << 4) + FILL_W'(16);
        issue      = (state == S_BR_RUN) && (fill_level <= FILL_W'(BUF_W));
        ret        = inflight[READ_LATENCY-1];

        k           = CNT_W'(bus.Consume_count);
        consume_req = bus.Consume_en && (bus.Consume_count != 5'd0) && (bus.Consume_count <= 5'd16);
        take        = consume_req && (k <= bit_count);

        if (Start) begin
            state_next     = S_BR_RUN;
            buffer_next    = '0;
            bit_count_next = '0;
            inflight_next  = '0;
            address_next   = Base_address;
            exhausted_next = 1'b0;
            underflow_next = 1'b0;
        end else begin
            if (take) k_eff = k;
            remain         = bit_count - k_eff;
            buffer_next    = buffer << k_eff;
            bit_count_next = remain;
            if (ret) begin
                // New word sits directly below whatever survives this cycle's consume.
                shamt          = CNT_W'(BUF_W - 16) - remain;
                buffer_next    = buffer_next | ({{(BUF_W-16){1'b0}}, bus.SRAM_read_data} << shamt);
                bit_count_next = remain + CNT_W'(16);
            end
            if (consume_req && !take) underflow_next = 1'b1;

            inflight_next = (inflight << 1) | READ_LATENCY'(issue);

            if (issue) begin
                if (address == END_ADDRESS) begin
                    exhausted_next = 1'b1;
                    state_next     = S_BR_DRAIN;
                end else begin
                    address_next = address + 18'd1;
                end
            end

            // Partial tail (<16 bits) is never handed out; drop it on the way to idle.
            if (state == S_BR_DRAIN && inflight == '0 && bit_count < CNT_W'(16)) begin
                state_next     = S_BR_IDLE;
                buffer_next    = '0;
                bit_count_next = '0;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= S_BR_IDLE;
            buffer    <= '0;
            bit_count <= '0;
            inflight  <= '0;
            address   <= '0;
            Exhausted <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            state     <= state_next;
            buffer    <= buffer_next;
            bit_count <= bit_count_next;
            inflight  <= inflight_next;
            address   <= address_next;
            Exhausted <= exhausted_next;
            Underflow <= underflow_next;
        end
    end

    assign bus.SRAM_address = address;
    assign bus.SRAM_we_n    = 1'b1;
    assign bus.Bits_out     = buffer[BUF_W-1 -: 16];
    assign bus.Bits_valid   = (bit_count >= CNT_W'(16));
    assign Busy             = (state != S_BR_IDLE);

    a_bit_count_bound: assert property (@(posedge Clock) disable iff (Reset)
        bit_count <= CNT_W'(BUF_W));
endmodule
